// File: rtl/glb_cfg_seq_if.sv
// GLB configuration bus: head-config outputs, CfgVld/CfgRdy handshake and the
// per-port reset/finish vectors. master = sequencer, slave = GLB.
interface glb_cfg_seq_if #(
   parameter int unsigned NUM_BANK   = 32,
   parameter int unsigned NUM_RDPORT = 4,
   parameter int unsigned NUM_WRPORT = 3,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned MAXPAR     = 32
);
   localparam int unsigned NP  = NUM_RDPORT + NUM_WRPORT;
   localparam int unsigned PW  = $clog2(MAXPAR) + 1;
   localparam int unsigned BPW = ($clog2(NUM_RDPORT) + $clog2(NUM_WRPORT)) * NUM_BANK;

   logic                       cfg_vld;
   logic                       cfg_rdy;
   logic [BPW-1:0]             bankport;
   logic [ADDR_WIDTH*NP-1:0]   addrmax;
   logic [PW*NUM_RDPORT-1:0]   rdpar;
   logic [PW*NUM_WRPORT-1:0]   wrpar;
   logic [NP-1:0]              port_rst;
   logic [NP-1:0]              port_fnh;

   modport master (
      output cfg_vld, bankport, addrmax, rdpar, wrpar, port_rst,
      input  cfg_rdy, port_fnh
   );

   modport slave (
      input  cfg_vld, bankport, addrmax, rdpar, wrpar, port_rst,
      output cfg_rdy, port_fnh
   );
endinterface

// File: rtl/glb_cfg_seq.sv
// Layer-configuration sequencer between CCU and GLB. Queues configurations and
// hands them to the GLB one at a time, waiting for all active ports to finish.
module glb_cfg_seq #(
   parameter int unsigned NUM_BANK   = 32,
   parameter int unsigned NUM_RDPORT = 4,
   parameter int unsigned NUM_WRPORT = 3,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned MAXPAR     = 32,
   parameter int unsigned CFG_DEPTH  = 4,
   parameter int unsigned TAG_W      = 8,
   parameter int unsigned TIMEOUT    = 65535,
   localparam int unsigned NP  = NUM_RDPORT + NUM_WRPORT,
   localparam int unsigned PW  = $clog2(MAXPAR) + 1,
   localparam int unsigned BPW = ($clog2(NUM_RDPORT) + $clog2(NUM_WRPORT)) * NUM_BANK
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_vld,
   output logic                      in_rdy,
   input  logic [BPW-1:0]            in_bankport,
   input  logic [ADDR_WIDTH*NP-1:0]  in_addrmax,
   input  logic [PW*NUM_RDPORT-1:0]  in_rdpar,
   input  logic [PW*NUM_WRPORT-1:0]  in_wrpar,
   input  logic [NP-1:0]             in_portmask,
   input  logic [TAG_W-1:0]          in_tag,
   input  logic                      abort,
   glb_cfg_seq_if.master             glb,
   output logic                      done,
   output logic [TAG_W-1:0]          done_tag,
   output logic                      busy,
   output logic                      err_timeout
);
   localparam int unsigned AW = $clog2(CFG_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);
   localparam logic [CW-1:0] DepthVal = CW'(CFG_DEPTH);

   typedef enum logic [2:0] {StIdle, StLoad, StCfg, StRst, StRun, StDone} state_e;

   // Queue storage
   logic [BPW-1:0]           fifo_bankport [CFG_DEPTH];
   logic [ADDR_WIDTH*NP-1:0] fifo_addrmax   [CFG_DEPTH];
   logic [PW*NUM_RDPORT-1:0] fifo_rdpar     [CFG_DEPTH];
   logic [PW*NUM_WRPORT-1:0] fifo_wrpar     [CFG_DEPTH];
   logic [NP-1:0]            fifo_mask      [CFG_DEPTH];
   logic [TAG_W-1:0]         fifo_tag       [CFG_DEPTH];

   state_e                   state_q, state_d;
   logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]            count_q, count_d;
   logic [BPW-1:0]           bankport_q, bankport_d;
   logic [ADDR_WIDTH*NP-1:0] addrmax_q, addrmax_d;
   logic [PW*NUM_RDPORT-1:0] rdpar_q, rdpar_d;
   logic [PW*NUM_WRPORT-1:0] wrpar_q, wrpar_d;
   logic [NP-1:0]            mask_q, mask_d, fnh_seen_q, fnh_seen_d, port_rst_q, port_rst_d;
   logic [TAG_W-1:0]         tag_q, tag_d, done_tag_q, done_tag_d;
   logic [15:0]              wdog_q, wdog_d;
   logic                     err_q, err_d, cfg_vld_q, cfg_vld_d, done_q, done_d;
   logic                     busy_q, busy_d, in_rdy_q, in_rdy_d;
   logic                     push, pop;
   logic [NP-1:0]            fnh_masked, fnh_all;

   // Next-state: FSM, queue pointers, watchdog and registered outputs
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      bankport_d = bankport_q;
      addrmax_d  = addrmax_q;
      rdpar_d    = rdpar_q;
      wrpar_d    = wrpar_q;
      mask_d     = mask_q;
      tag_d      = tag_q;
      fnh_seen_d = fnh_seen_q;
      wdog_d     = wdog_q;
      err_d      = err_q;
      pop        = 1'b0;
      push       = in_vld && in_rdy_q && !abort;
      fnh_masked = glb.port_fnh & mask_q;
      fnh_all    = fnh_seen_q | fnh_masked;

      unique case (state_q)
         StIdle: if (count_q != '0) state_d = StLoad;
         StLoad: begin
            bankport_d = fifo_bankport[rd_ptr_q];
            addrmax_d  = fifo_addrmax[rd_ptr_q];
            rdpar_d    = fifo_rdpar[rd_ptr_q];
            wrpar_d    = fifo_wrpar[rd_ptr_q];
            mask_d     = fifo_mask[rd_ptr_q];
            tag_d      = fifo_tag[rd_ptr_q];
            state_d    = StCfg;
         end
         StCfg: if (glb.cfg_rdy) state_d = StRst;
         StRst: begin
            fnh_seen_d = '0;
            wdog_d     = '0;
            state_d    = StRun;
         end
         StRun: begin
            fnh_seen_d = fnh_all;
            if (fnh_all == mask_q) begin
               state_d = StDone;
            end else if ((fnh_masked & ~fnh_seen_q) != '0) begin
               wdog_d = '0;
            end else if (wdog_q != TimeoutVal) begin
               // Saturates at TIMEOUT; the error flag stays until abort/reset.
               wdog_d = wdog_q + 16'd1;
               if (wdog_d == TimeoutVal) err_d = 1'b1;
            end
         end
         StDone: begin
            pop     = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);

      if (abort) begin
         state_d    = StIdle;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         fnh_seen_d = '0;
         wdog_d     = '0;
         err_d      = 1'b0;
      end

      // Outputs are registered copies of what the next state implies.
      cfg_vld_d  = (state_d == StCfg);
      port_rst_d = abort ? {NP{1'b1}} : ((state_d == StRst) ? mask_d : '0);
      done_d     = (state_d == StDone);
      done_tag_d = done_d ? tag_q : '0;
      busy_d     = (state_d != StIdle) || (count_d != '0);
      in_rdy_d   = (count_d != DepthVal);
   end

   // Queue write port; entries are only read after being written
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_bankport[wr_ptr_q] <= in_bankport;
         fifo_addrmax[wr_ptr_q]  <= in_addrmax;
         fifo_rdpar[wr_ptr_q]    <= in_rdpar;
         fifo_wrpar[wr_ptr_q]    <= in_wrpar;
         fifo_mask[wr_ptr_q]     <= in_portmask;
         fifo_tag[wr_ptr_q]      <= in_tag;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         bankport_q <= '0;
         addrmax_q  <= '0;
         rdpar_q    <= '0;
         wrpar_q    <= '0;
         mask_q     <= '0;
         tag_q      <= '0;
         fnh_seen_q <= '0;
         wdog_q     <= '0;
         err_q      <= 1'b0;
         cfg_vld_q  <= 1'b0;
         port_rst_q <= '0;
         done_q     <= 1'b0;
         done_tag_q <= '0;
         busy_q     <= 1'b0;
         in_rdy_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         bankport_q <= bankport_d;
         addrmax_q  <= addrmax_d;
         rdpar_q    <= rdpar_d;
         wrpar_q    <= wrpar_d;
         mask_q     <= mask_d;
         tag_q      <= tag_d;
         fnh_seen_q <= fnh_seen_d;
         wdog_q     <= wdog_d;
         err_q      <= err_d;
         cfg_vld_q  <= cfg_vld_d;
         port_rst_q <= port_rst_d;
         done_q     <= done_d;
         done_tag_q <= done_tag_d;
         busy_q     <= busy_d;
         in_rdy_q   <= in_rdy_d;
      end
   end

   assign in_rdy       = in_rdy_q;
   assign glb.cfg_vld  = cfg_vld_q;
   assign glb.bankport = bankport_q;
   assign glb.addrmax  = addrmax_q;
   assign glb.rdpar    = rdpar_q;
   assign glb.wrpar    = wrpar_q;
   assign glb.port_rst = port_rst_q;
   assign done         = done_q;
   assign done_tag     = done_tag_q;
   assign busy         = busy_q;
   assign err_timeout  = err_q;
endmodule

// File: tb/tb_glb_cfg_seq.sv
// Self-checking bench for glb_cfg_seq: directed layers plus a done-tag scoreboard.
module tb_glb_cfg_seq;
   localparam int unsigned NP = 7;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_vld, in_rdy, abort;
   logic [127:0] in_bankport;
   logic [111:0] in_addrmax;
   logic [23:0]  in_rdpar;
   logic [17:0]  in_wrpar;
   logic [6:0]   in_portmask;
   logic [7:0]   in_tag;
   logic         done, busy, err_timeout;
   logic [7:0]   done_tag;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q[$];

   glb_cfg_seq_if glb_if ();

   glb_cfg_seq #(.TIMEOUT(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_vld      (in_vld),
      .in_rdy      (in_rdy),
      .in_bankport (in_bankport),
      .in_addrmax  (in_addrmax),
      .in_rdpar    (in_rdpar),
      .in_wrpar    (in_wrpar),
      .in_portmask (in_portmask),
      .in_tag      (in_tag),
      .abort       (abort),
      .glb         (glb_if),
      .done        (done),
      .done_tag    (done_tag),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input logic [7:0] tag, input logic [6:0] mask, input logic [15:0] amax);
      in_tag      = tag;
      in_portmask = mask;
      in_addrmax  = {7{amax}};
      in_bankport = {$urandom, $urandom, $urandom, $urandom};
      in_rdpar    = 24'($urandom);
      in_wrpar    = 18'($urandom);
   endtask

   // Push one config (in_vld left high for the caller to drop).
   task automatic push_cfg(input logic [7:0] tag, input logic [6:0] mask, input logic [15:0] amax);
      int n = 0;
      set_cfg(tag, mask, amax);
      in_vld = 1'b1;
      while (!in_rdy && n < 50) begin tick(); n++; end
      chk("push_rdy", in_rdy, 1'b1);
      tick();
      exp_q.push_back(tag);
   endtask

   task automatic wait_vld();
      int n = 0;
      while (!glb_if.cfg_vld && n < 50) begin tick(); n++; end
      chk("vld_wait", glb_if.cfg_vld, 1'b1);
   endtask

   // Play the GLB side for one layer: accept, then finish all masked ports at once.
   task automatic serve(input logic [6:0] mask);
      wait_vld();
      glb_if.cfg_rdy = 1'b1;
      tick();
      glb_if.cfg_rdy = 1'b0;
      chk("srv_rst", glb_if.port_rst, mask);
      tick();
      glb_if.port_fnh = mask;
      tick();
      glb_if.port_fnh = '0;
      chk("srv_done", done, 1'b1);
      tick();
   endtask

   // Scoreboard: every done must match the oldest outstanding tag.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) chk("done_unexp", done, 1'b0);
         else chk("done_tag", done_tag, exp_q.pop_front());
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [127:0] e_bp;
      logic [111:0] e_am;
      logic [23:0]  e_rp;
      logic [17:0]  e_wp;
      rst_n = 1'b0; in_vld = 1'b0; abort = 1'b0;
      set_cfg(8'h00, 7'h00, 16'h0);
      glb_if.cfg_rdy = 1'b0; glb_if.port_fnh = '0;
      tick(2);
      chk("rst_in_rdy", in_rdy, 1'b1);
      chk("rst_vld", glb_if.cfg_vld, 1'b0);
      chk("rst_port_rst", glb_if.port_rst, 7'h0);
      chk("rst_bankport", glb_if.bankport, 128'h0);
      chk("rst_done", {done, done_tag}, 9'h0);
      chk("rst_busy_err", {busy, err_timeout}, 2'b00);
      rst_n = 1'b1;
      tick();

      // Single layer, bits finishing one per cycle
      glb_if.cfg_rdy = 1'b1;
      push_cfg(8'h11, 7'h7F, 16'h00FF);
      in_vld = 1'b0;
      chk("sl_busy", busy, 1'b1);
      wait_vld();
      chk("sl_addrmax", glb_if.addrmax, {7{16'h00FF}});
      tick();
      glb_if.cfg_rdy = 1'b0;
      chk("sl_vld_1cyc", glb_if.cfg_vld, 1'b0);
      chk("sl_port_rst", glb_if.port_rst, 7'h7F);
      tick();
      chk("sl_port_rst_1cyc", glb_if.port_rst, 7'h00);
      for (int i = 0; i < 7; i++) begin
         glb_if.port_fnh = 7'(1 << i);
         tick();
         if (i < 6) chk("sl_no_early_done", done, 1'b0);
      end
      glb_if.port_fnh = '0;
      chk("sl_done", done, 1'b1);
      chk("sl_done_tag", done_tag, 8'h11);
      tick();
      chk("sl_done_1cyc", done, 1'b0);
      tick();
      chk("sl_idle", busy, 1'b0);

      // Queue full and ordering
      for (int t = 1; t <= 4; t++) push_cfg(8'(t), 7'h7F, 16'(t));
      chk("qf_full", in_rdy, 1'b0);
      set_cfg(8'd5, 7'h7F, 16'd5);
      tick(3);
      chk("qf_held", in_rdy, 1'b0);
      serve(7'h7F);
      begin
         int n = 0;
         while (!in_rdy && n < 20) begin tick(); n++; end
      end
      chk("qf_rdy_back", in_rdy, 1'b1);
      tick();
      in_vld = 1'b0;
      exp_q.push_back(8'd5);
      for (int t = 0; t < 4; t++) serve(7'h7F);
      tick(10);
      chk("qf_drained", exp_q.size(), 0);
      chk("qf_idle", busy, 1'b0);

      // Partial mask with GLB backpressure
      push_cfg(8'h22, 7'h09, 16'h1234);
      in_vld = 1'b0;
      e_bp = in_bankport; e_am = in_addrmax; e_rp = in_rdpar; e_wp = in_wrpar;
      wait_vld();
      for (int i = 0; i < 10; i++) begin
         chk("bp_vld", glb_if.cfg_vld, 1'b1);
         chk("bp_cfg", {glb_if.bankport, glb_if.addrmax[15:0], glb_if.rdpar, glb_if.wrpar},
             {e_bp, e_am[15:0], e_rp, e_wp});
         tick();
      end
      chk("bp_addrmax", glb_if.addrmax, e_am);
      glb_if.cfg_rdy = 1'b1;
      tick();
      glb_if.cfg_rdy = 1'b0;
      chk("bp_port_rst", glb_if.port_rst, 7'h09);
      tick();
      glb_if.port_fnh = 7'h76;
      tick();
      glb_if.port_fnh = '0;
      chk("bp_no_done_76", done, 1'b0);
      tick();
      chk("bp_no_done_gap", done, 1'b0);
      glb_if.port_fnh = 7'h09;
      tick();
      glb_if.port_fnh = '0;
      chk("bp_done", done, 1'b1);
      tick(2);

      // Empty mask
      push_cfg(8'h33, 7'h00, 16'h0);
      in_vld = 1'b0;
      wait_vld();
      glb_if.cfg_rdy = 1'b1;
      tick();
      glb_if.cfg_rdy = 1'b0;
      chk("em_port_rst", glb_if.port_rst, 7'h00);
      tick();
      chk("em_run_no_done", done, 1'b0);
      tick();
      chk("em_done", done, 1'b1);
      tick(2);

      // Watchdog, then abort clears it
      push_cfg(8'h44, 7'h01, 16'h0);
      in_vld = 1'b0;
      wait_vld();
      glb_if.cfg_rdy = 1'b1;
      tick();
      glb_if.cfg_rdy = 1'b0;
      tick();
      glb_if.port_fnh = 7'h7E;
      tick(15);
      chk("wd_not_yet", err_timeout, 1'b0);
      tick();
      chk("wd_err", err_timeout, 1'b1);
      tick(5);
      glb_if.port_fnh = '0;
      chk("wd_sticky", {err_timeout, busy, done}, 3'b110);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      exp_q.delete();
      chk("wd_ab_rst", glb_if.port_rst, 7'h7F);
      chk("wd_ab_err_busy", {err_timeout, busy}, 2'b00);
      tick();
      chk("wd_ab_rst_1cyc", glb_if.port_rst, 7'h00);

      // Abort during CFG with three entries queued
      for (int t = 0; t < 3; t++) push_cfg(8'(8'h51 + t), 7'h7F, 16'h0);
      in_vld = 1'b0;
      wait_vld();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      exp_q.delete();
      chk("ab_vld", glb_if.cfg_vld, 1'b0);
      chk("ab_empty", {busy, in_rdy}, 2'b01);
      tick(10);
      chk("ab_no_restart", {glb_if.cfg_vld, busy}, 2'b00);

      // Push coincident with abort is discarded
      set_cfg(8'h5A, 7'h7F, 16'h0);
      in_vld = 1'b1;
      abort = 1'b1;
      tick();
      in_vld = 1'b0;
      abort = 1'b0;
      tick(5);
      chk("abp_discard", {glb_if.cfg_vld, busy}, 2'b00);

      // Asynchronous reset mid-RUN
      push_cfg(8'h66, 7'h7F, 16'hBEEF);
      in_vld = 1'b0;
      wait_vld();
      glb_if.cfg_rdy = 1'b1;
      tick();
      glb_if.cfg_rdy = 1'b0;
      tick();
      glb_if.port_fnh = 7'h03;
      tick(2);
      chk("ar_pre_busy", busy, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("ar_cfg", {glb_if.bankport, glb_if.addrmax}, 240'h0);
      chk("ar_ctl", {glb_if.cfg_vld, glb_if.port_rst, done, done_tag, busy, err_timeout, in_rdy},
          20'h00001);
      glb_if.port_fnh = '0;
      tick();
      rst_n = 1'b1;
      tick(3);
      chk("ar_idle", {glb_if.cfg_vld, busy}, 2'b00);

      chk("sb_final", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
